// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - memory-op package plus request/memory/completion interface for mem_access_unit
//
// Package mem_access_unit_pkg: decode_mem_op_t (OP_MEM_LD, OP_MEM_LDU, OP_MEM_ST).
// Interface mem_access_unit_if #(XLEN, TAG_W):
//   pipeline request : i_req_valid, o_req_ready, i_op, i_addr, i_size, i_misalign, i_st_data, i_tag
//   memory port      : o_mem_valid, i_mem_ready, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wmask,
//                      i_mem_rvalid, i_mem_rdata, i_mem_err
//   completion       : o_resp_valid, i_resp_ready, o_resp_data, o_resp_tag, o_resp_fault
// Signal prefixes are from the unit's point of view; modport slave is the unit, master its environment.

package mem_access_unit_pkg;
    typedef enum logic [1:0] {
        OP_MEM_LD  = 2'd0,
        OP_MEM_LDU = 2'd1,
        OP_MEM_ST  = 2'd2
    } decode_mem_op_t;
endpackage

interface mem_access_unit_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
);
    import mem_access_unit_pkg::*;

    logic                 i_req_valid;
    logic                 o_req_ready;
    decode_mem_op_t       i_op;
    logic [XLEN-1:0]      i_addr;
    logic [1:0]           i_size;
    logic                 i_misalign;
    logic [XLEN-1:0]      i_st_data;
    logic [TAG_W-1:0]     i_tag;

    logic                 o_mem_valid;
    logic                 i_mem_ready;
    logic [XLEN-1:0]      o_mem_addr;
    logic                 o_mem_we;
    logic [63:0]          o_mem_wdata;
    logic [7:0]           o_mem_wmask;
    logic                 i_mem_rvalid;
    logic [63:0]          i_mem_rdata;
    logic                 i_mem_err;

    logic                 o_resp_valid;
    logic                 i_resp_ready;
    logic [XLEN-1:0]      o_resp_data;
    logic [TAG_W-1:0]     o_resp_tag;
    logic [1:0]           o_resp_fault;

    modport slave (
        input  i_req_valid, i_op, i_addr, i_size, i_misalign, i_st_data, i_tag,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err, i_resp_ready,
        output o_req_ready, o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wmask,
        output o_resp_valid, o_resp_data, o_resp_tag, o_resp_fault
    );

    modport master (
        output i_req_valid, i_op, i_addr, i_size, i_misalign, i_st_data, i_tag,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err, i_resp_ready,
        input  o_req_ready, o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wmask,
        input  o_resp_valid, o_resp_data, o_resp_tag, o_resp_fault
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding data-memory access unit (load align/extend, store lanes)
//
// Ports:
//   i_clk, i_rst_n (asynchronous, active-low)
//   i_log_fd  trace file descriptor, no functional effect
//   bus       mem_access_unit_if.slave: pipeline request, 64-bit memory port, completion
// Optional feature macro: MEM_RESP_TIMEOUT_EN -- when defined, WAIT gives up after
// TIMEOUT_CYCLES cycles without a response and completes with fault 3.
// Fault codes: 0 none, 1 misalign, 2 bus error, 3 timeout.

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_log_fd,
    mem_access_unit_if.slave     bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic              req_ready_q;
    logic              mem_valid_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic              mem_we_q;
    logic [63:0]       mem_wdata_q;
    logic [7:0]        mem_wmask_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [1:0]        resp_fault_q;

    // Latched request fields needed after the memory request has been issued.
    logic [2:0]        lat_off;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic              lat_store;

    logic              unused_log;
    assign unused_log = ^i_log_fd;

`ifdef MEM_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  wait_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        case (size)
            2'b00:   m = 16'h0001;
            2'b01:   m = 16'h0003;
            2'b10:   m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        m = m << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] lane_data(input logic [XLEN-1:0] st, input logic [2:0] off);
        logic [63:0] d;
        d = 64'(st);
        return d << {off, 3'b000};
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [63:0] rdata, input logic [2:0] off,
                                                     input logic [1:0] size, input logic sgn);
        logic [63:0] sh;
        logic [63:0] r;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   r = {{56{sgn & sh[7]}},  sh[7:0]};
            2'b01:   r = {{48{sgn & sh[15]}}, sh[15:0]};
            2'b10:   r = {{32{sgn & sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return XLEN'(r);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            resp_fault_q <= '0;
            lat_off      <= '0;
            lat_size     <= '0;
            lat_signed   <= 1'b0;
            lat_store    <= 1'b0;
`ifdef MEM_RESP_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Ready is held low for the first cycle out of reset so that
                    // every output reads 0 while reset is asserted.
                    if (req_ready_q && bus.i_req_valid) begin
                        req_ready_q <= 1'b0;
                        lat_off     <= bus.i_addr[2:0];
                        lat_size    <= bus.i_size;
                        lat_signed  <= (bus.i_op == OP_MEM_LD);
                        lat_store   <= (bus.i_op == OP_MEM_ST);
                        resp_tag_q  <= bus.i_tag;
                        if (bus.i_misalign) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 2'd1;
                            resp_data_q  <= '0;
                        end else begin
                            state       <= S_REQ;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {bus.i_addr[XLEN-1:3], 3'b000};
                            if (bus.i_op == OP_MEM_ST) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= lane_data(bus.i_st_data, bus.i_addr[2:0]);
                                mem_wmask_q <= lane_mask(bus.i_size, bus.i_addr[2:0]);
                            end else begin
                                mem_we_q    <= 1'b0;
                                mem_wdata_q <= '0;
                                mem_wmask_q <= '0;
                            end
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (bus.i_mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state       <= S_WAIT;
`ifdef MEM_RESP_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        state        <= S_RESP;
                        resp_valid_q <= 1'b1;
                        if (bus.i_mem_err) begin
                            resp_fault_q <= 2'd2;
                            resp_data_q  <= '0;
                        end else begin
                            resp_fault_q <= 2'd0;
                            resp_data_q  <= lat_store ? '0 :
                                            load_extend(bus.i_mem_rdata, lat_off, lat_size, lat_signed);
                        end
                    end
`ifdef MEM_RESP_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state        <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 2'd3;
                        resp_data_q  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (bus.i_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready  = req_ready_q;
    assign bus.o_mem_valid  = mem_valid_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_wdata  = mem_wdata_q;
    assign bus.o_mem_wmask  = mem_wmask_q;
    assign bus.o_resp_valid = resp_valid_q;
    assign bus.o_resp_data  = resp_data_q;
    assign bus.o_resp_tag   = resp_tag_q;
    assign bus.o_resp_fault = resp_fault_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Downstream consumer of address-generation results: takes one generated memory request per transaction (address, size, op, misalign flag, store data) and performs the data-memory access.
- Handshakes with the memory port, aligns and extends load data, builds store byte lanes, and returns one completion per request to the pipeline.
- Single outstanding transaction; blocking.

Parameters:
- XLEN, 64, register/data width; the memory port is 64 bits, 8 byte lanes.
- TAG_W, 4, width of the pipeline tag carried from request to completion.
- TIMEOUT_CYCLES, 256, response-wait limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_log_fd  in  32  trace file descriptor; no functional effect
- i_req_valid  in  1  request valid
- o_req_ready  out  1  unit can accept a request
- i_op  in  decode_mem_op_t  OP_MEM_LD, OP_MEM_LDU or OP_MEM_ST
- i_addr  in  XLEN  generated byte address
- i_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
- i_misalign  in  1  misalign flag from address generation
- i_st_data  in  XLEN  store data, right-justified
- i_tag  in  TAG_W  pipeline tag
- o_mem_valid  out  1  memory request valid
- i_mem_ready  in  1  memory accepts request
- o_mem_addr  out  XLEN  8-byte-aligned address {addr[XLEN-1:3],3'b000}
- o_mem_we  out  1  write
- o_mem_wdata  out  64  lane-shifted store data
- o_mem_wmask  out  8  byte-lane enables
- i_mem_rvalid  in  1  response valid, for both loads and stores
- i_mem_rdata  in  64  read data
- i_mem_err  in  1  bus error, qualified by i_mem_rvalid
- o_resp_valid  out  1  completion valid
- i_resp_ready  in  1  pipeline accepts completion
- o_resp_data  out  XLEN  load result; 0 for stores and faults
- o_resp_tag  out  TAG_W  tag of the completing request
- o_resp_fault  out  2  0=none, 1=misalign, 2=bus error, 3=timeout

Behaviour:
- Reset: all outputs 0, state IDLE, latched request cleared. Reset mid-transaction abandons the transaction. Responses arriving after reset are ignored because the unit is in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- o_req_ready = (state == IDLE).
- IDLE, on i_req_valid: latch op, addr, size, st_data and tag.
  - If i_misalign: go to RESP with fault=1; no memory access.
  - Otherwise: go to REQ.
- REQ: drive o_mem_valid=1 with address/we/wdata/wmask held stable until i_mem_ready; then go to WAIT. o_mem_valid drops the cycle after acceptance.
- WAIT: on i_mem_rvalid, capture the result and go to RESP. i_mem_rvalid in any other state is ignored.
- RESP: hold o_resp_valid=1 with data, tag and fault stable until i_resp_ready; then go to IDLE.
- Minimum latency, with i_mem_ready=1 and rvalid on the first WAIT cycle:
  - request accepted at cycle 0;
  - o_mem_valid at cycle 1;
  - rvalid at cycle 2;
  - o_resp_valid at cycle 3.
- Misaligned request: o_resp_valid at cycle 1.
- Byte offset: off = addr[2:0]; nbytes = 1<<size.
- Store lanes:
  - o_mem_wdata = st_data << (8*off);
  - o_mem_wmask = ((1<<nbytes)-1) << off.
- Loads: o_mem_we=0, o_mem_wmask=0.
- Load data:
  - raw = i_mem_rdata >> (8*off), truncated to nbytes;
  - OP_MEM_LD sign-extends to XLEN, OP_MEM_LDU zero-extends;
  - size 11 yields all 64 bits for either op.
- i_mem_err with rvalid: fault=2, data=0.
- Store completion: data=0, fault=0 unless error.
- Back-to-back: a new request is accepted no earlier than the cycle after the RESP handshake.

Optional Feature:
- Macro: MEM_RESP_TIMEOUT_EN.
- Enabled:
  - a counter clears on entry to WAIT and increments each WAIT cycle without i_mem_rvalid;
  - on reaching TIMEOUT_CYCLES, go to RESP with fault=3, data=0;
  - a late rvalid is then ignored.
- Disabled: no counter; WAIT lasts indefinitely.

Test Plan:
- LD, addr=0x1003, size=00, rdata=0x00000000_80000000 -> wmask 0, o_mem_addr=0x1000; byte 0x80 -> resp_data=0xFFFF_FFFF_FFFF_FF80, fault 0, at cycle 3 with zero-wait memory.
- LDU, addr=0x2004, size=10, rdata=0xDEADBEEF_00000000 -> resp_data=0x00000000_DEADBEEF.
- ST, addr=0x3006, size=01, st_data=0x1234 -> wdata=0x1234_0000_0000_0000, wmask=0xC0, we=1; completion data 0, fault 0.
- i_misalign=1 (addr=0x4001, size=01) -> no o_mem_valid, resp fault=1 at cycle 1; with i_resp_ready held 0 for 5 cycles, o_resp_valid, tag and fault stay stable and o_req_ready stays 0.
- i_mem_ready low 3 cycles, then rvalid with i_mem_err=1 -> address stable while stalled; resp fault=2, data 0; assert i_rst_n=0 in WAIT on a second request -> all outputs 0 immediately; a following rvalid produces no completion.
- MEM_RESP_TIMEOUT_EN with TIMEOUT_CYCLES=8, no rvalid -> fault=3 after 8 WAIT cycles; rvalid one cycle later is ignored.
